pha: RTL and testbench
======================

# pha

Pulse height analyzer placed directly downstream of the pole-zero/high-pass stage. It consumes that stage's signed sample stream and arms on a threshold crossing. For each pulse it records the peak amplitude and the time-to-peak. It then delivers one result per pulse through a valid/ready handshake, with programmable dead time and over-length (pile-up) rejection.

## Interface
- Nbits, 14, width of signed samples, threshold and peak result
- Cbits, 12, width of unsigned sample counters (time-to-peak, max length, hold-off)

- clk  in  1  system clock; all state updates on rising edge
- clr  in  1  synchronous, active-high reset
- en  in  1  sample strobe; X is consumed only in cycles with en=1
- X  in  Nbits signed  input sample (output of the high-pass stage)
- thr  in  Nbits signed  trigger threshold; sample is "above" when X > thr
- maxlen  in  Cbits unsigned  maximum accepted pulse length in samples
- nhold  in  Cbits unsigned  dead-time samples after pulse end
- rdy  in  1  consumer ready
- H  out  Nbits signed  peak amplitude of reported pulse
- T  out  Cbits unsigned  sample index of peak relative to trigger sample (trigger = 0)
- valid  out  1  result H/T available
- drop  out  1  one-cycle pulse: over-length pulse discarded
- ovf  out  1  sticky: a result was lost due to backpressure
- busy  out  1  state != IDLE

## Operation
- Reset (clr=1 on an edge) puts the block in the IDLE state. All of H, T, valid, drop, ovf and busy go to 0, and all internal counters are cleared. clr has priority over every other event, including mid-pulse; a partial pulse is discarded with no result.
- States: IDLE, TRACK, HOLD. Transitions happen only on cycles with en=1, except for the output handshake and clearing of drop.
- IDLE: if X > thr, latch pk=X, tpk=0, cnt=1, clear the long flag, and go to TRACK. Otherwise remain in IDLE.
- TRACK, when X > thr:
  - If X > pk (strict, signed), set pk=X and tpk=cnt. On ties the earliest maximum is kept.
  - Increment cnt, saturating at 2^Cbits-1.
  - If cnt ≥ maxlen before the increment, set long=1.
- TRACK, when X ≤ thr (pulse end; this sample is not part of the pulse):
  - If long=0, emit (H,T)=(pk,tpk).
  - If long=1, pulse drop for one cycle and emit nothing.
  - Next state is HOLD with hold=nhold, or IDLE directly if nhold=0.
- Because long is set when cnt ≥ maxlen, pulses whose above-threshold length is ≤ maxlen are accepted. maxlen=0 rejects every pulse.
- HOLD: the threshold is ignored. Each en decrements hold; when hold reaches 0 (checked after the decrement), go to IDLE. nhold=N therefore blocks exactly N samples.
- Output handshake:
  - A transfer occurs in any cycle with valid=1 and rdy=1.
  - On emit with valid=0, or with valid=1 and rdy=1 in the same cycle: load H/T and set valid=1.
  - On emit with valid=1 and rdy=0: the new result is discarded, ovf is set, and H/T are unchanged.
  - Without an emit, a transfer clears valid.
  - H and T are stable while valid=1 and rdy=0.
- ovf is cleared only by clr.
- Arithmetic: all comparisons are signed Nbits (X vs thr, X vs pk). Counters are unsigned Cbits. No widening is needed.

## Timing
- A sample is consumed at the rising edge where en=1.
- valid rises on the edge that consumes the pulse-ending sample, so it is visible the cycle after that sample is presented. Latency from pulse end is 1 clk.
- drop is asserted for exactly one clk, on the same edge where the result would otherwise have been emitted.
- busy rises on the edge that consumes the trigger sample and falls on the edge entering IDLE.
- With en=0 the state, counters, pk, tpk and hold are frozen; the output handshake still operates.
- A new trigger is possible on the first en sample after entering IDLE.
- Throughput: one result per pulse; no internal FIFO.

## Test plan
- Basic pulse: thr=100, maxlen=16, nhold=0, rdy=1, en=1, X=50,120,300,250,90 → valid=1 for one cycle after 90 is presented, with H=300, T=1; busy=0 afterwards.
- Tie and en gaps: X=150,200,200,80 with en toggling 1,0,1,0,… → H=200, T=1 (first maximum); no state change on en=0 cycles.
- Hold-off: nhold=3, pulse 150,90, then 500,500,500,500 → one result H=150 T=0. The first three 500 samples are ignored and the fourth re-triggers; busy stays high throughout.
- Over-length: maxlen=2, X=150,160,170,50 → drop pulses once, no valid. With maxlen=3 the same stimulus gives H=170, T=2.
- Backpressure: rdy=0, two pulses (peaks 300 then 400) → H=300 is held, valid stays 1, ovf=1. Raising rdy transfers 300 and valid falls. A third pulse ending in the same cycle as rdy=1 → H=new peak, valid stays 1.
- Mid-pulse reset: clr=1 during TRACK (after X=300) → next cycle busy=0, valid=0, ovf=0. A subsequent pulse 120,90 reports H=120, T=0.

Source files
------------

// File: rtl/pha.sv
// rtl/pha.sv - pulse height analyzer: peak amplitude and time-to-peak per pulse,
// with dead time, over-length rejection and a single-entry valid/ready result.
module pha #(
  parameter int Nbits = 14,
  parameter int Cbits = 12
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [Nbits-1:0] X,
  input  logic signed [Nbits-1:0] thr,
  input  logic        [Cbits-1:0] maxlen,
  input  logic        [Cbits-1:0] nhold,
  input  logic                    rdy,
  output logic signed [Nbits-1:0] H,
  output logic        [Cbits-1:0] T,
  output logic                    valid,
  output logic                    drop,
  output logic                    ovf,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

  state_t                  state, state_nxt;
  logic signed [Nbits-1:0] pk;
  logic        [Cbits-1:0] tpk;
  logic        [Cbits-1:0] cnt;
  logic        [Cbits-1:0] hold;
  logic                    long_f;
  logic                    above;
  logic                    pulse_end;
  logic                    emit;
  logic                    drop_evt;

  assign above = X > thr;

  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (en) begin
      case (state)
        IDLE:    if (above) state_nxt = TRACK;
        TRACK:   if (!above) state_nxt = (nhold == '0) ? IDLE : HOLD;
        HOLD:    if (hold <= Cbits'(1)) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state != IDLE);
    pulse_end = en && (state == TRACK) && !above;
    emit      = pulse_end && !long_f;
    drop_evt  = pulse_end && long_f;
  end

  // Pulse datapath; frozen whenever en=0.
  always_ff @(posedge clk) begin
    if (clr) begin
      pk     <= '0;
      tpk    <= '0;
      cnt    <= '0;
      hold   <= '0;
      long_f <= 1'b0;
    end else if (en) begin
      case (state)
        IDLE: if (above) begin
          pk     <= X;
          tpk    <= '0;
          cnt    <= Cbits'(1);
          // The trigger sample alone already exceeds a zero length limit.
          long_f <= (maxlen == '0);
        end
        TRACK: if (above) begin
          if (X > pk) begin
            pk  <= X;
            tpk <= cnt;
          end
          if (cnt != '1) cnt <= cnt + Cbits'(1);
          if (cnt >= maxlen) long_f <= 1'b1;
        end else begin
          hold <= nhold;
        end
        HOLD:    hold <= hold - Cbits'(1);
        default: ;
      endcase
    end
  end

  // Single result slot: a new result may overwrite only when the old one leaves.
  always_ff @(posedge clk) begin
    if (clr) begin
      H     <= '0;
      T     <= '0;
      valid <= 1'b0;
      drop  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      drop <= drop_evt;
      if (emit && (!valid || rdy)) begin
        H     <= pk;
        T     <= tpk;
        valid <= 1'b1;
      end else if (emit) begin
        ovf <= 1'b1;
      end else if (valid && rdy) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pha.sv
// tb/tb_pha.sv - directed bench for pha with hand-computed expectations.
module tb_pha;

  logic               clk = 1'b0;
  logic               clr;
  logic               en;
  logic signed [13:0] X;
  logic signed [13:0] thr;
  logic        [11:0] maxlen;
  logic        [11:0] nhold;
  logic               rdy;
  logic signed [13:0] H;
  logic        [11:0] T;
  logic               valid, drop, ovf, busy;

  int checks = 0;
  int failures = 0;

  pha dut (
    .clk(clk), .clr(clr), .en(en), .X(X), .thr(thr), .maxlen(maxlen),
    .nhold(nhold), .rdy(rdy), .H(H), .T(T), .valid(valid), .drop(drop),
    .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic e, input int x);
    en = e;
    X  = 14'(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b1; en = 1'b0; X = '0; thr = 14'sd100;
    maxlen = 12'd16; nhold = 12'd0; rdy = 1'b1;
    step(0, 0);
    step(0, 0);
    clr = 1'b0;
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_drop", drop, 0);
    chk("rst_H", H, 0);
    chk("rst_T", T, 0);

    // Basic pulse
    step(1, 50);
    chk("basic_idle_busy", busy, 0);
    step(1, 120);
    chk("basic_trig_busy", busy, 1);
    step(1, 300);
    step(1, 250);
    chk("basic_novalid_yet", valid, 0);
    step(1, 90);
    chk("basic_valid", valid, 1);
    chk("basic_H", H, 300);
    chk("basic_T", T, 1);
    chk("basic_busy_after", busy, 0);
    step(1, 50);
    chk("basic_valid_fall", valid, 0);

    // Tie with en gaps; en=0 samples above any peak must be ignored
    step(1, 150);
    step(0, 999);
    chk("gap_busy", busy, 1);
    step(1, 200);
    step(0, 999);
    step(1, 200);
    step(0, 50);
    chk("gap_no_end_on_en0", valid, 0);
    chk("gap_busy2", busy, 1);
    step(1, 80);
    chk("tie_valid", valid, 1);
    chk("tie_H", H, 200);
    chk("tie_T", T, 1);
    step(0, 0);
    chk("tie_valid_fall", valid, 0);

    // Hold-off of three samples
    nhold = 12'd3;
    step(1, 150);
    step(1, 90);
    chk("hold_valid", valid, 1);
    chk("hold_H", H, 150);
    chk("hold_T", T, 0);
    chk("hold_busy", busy, 1);
    step(1, 500);
    step(1, 500);
    step(1, 500);
    chk("hold_nores", valid, 0);
    step(1, 600);
    chk("hold_retrig_busy", busy, 1);
    nhold = 12'd0;
    step(1, 50);
    chk("hold2_H", H, 600);
    chk("hold2_T", T, 0);
    chk("hold2_busy", busy, 0);
    step(0, 0);

    // Over-length rejection
    maxlen = 12'd2;
    step(1, 150); step(1, 160); step(1, 170);
    step(1, 50);
    chk("long_drop", drop, 1);
    chk("long_novalid", valid, 0);
    step(1, 50);
    chk("long_drop_once", drop, 0);
    maxlen = 12'd3;
    step(1, 150); step(1, 160); step(1, 170);
    step(1, 50);
    chk("len3_drop", drop, 0);
    chk("len3_valid", valid, 1);
    chk("len3_H", H, 170);
    chk("len3_T", T, 2);
    step(0, 0);
    maxlen = 12'd0;
    step(1, 150);
    step(1, 50);
    chk("len0_drop", drop, 1);
    chk("len0_novalid", valid, 0);
    maxlen = 12'd16;
    step(0, 0);

    // Backpressure
    rdy = 1'b0;
    step(1, 300); step(1, 90);
    chk("bp_valid1", valid, 1);
    chk("bp_H1", H, 300);
    chk("bp_ovf0", ovf, 0);
    step(1, 400); step(1, 90);
    chk("bp_ovf", ovf, 1);
    chk("bp_held_H", H, 300);
    chk("bp_held_valid", valid, 1);
    rdy = 1'b1;
    step(0, 0);
    chk("bp_xfer_fall", valid, 0);
    rdy = 1'b0;
    step(1, 450); step(1, 90);
    chk("bp_H2", H, 450);
    step(1, 500);
    rdy = 1'b1;
    step(1, 90);
    chk("bp_same_cycle_valid", valid, 1);
    chk("bp_same_cycle_H", H, 500);
    chk("bp_same_cycle_T", T, 0);
    step(0, 0);
    chk("bp_final_fall", valid, 0);
    chk("bp_ovf_sticky", ovf, 1);

    // Mid-pulse reset
    step(1, 120); step(1, 300);
    chk("mid_busy", busy, 1);
    clr = 1'b1;
    step(1, 400);
    clr = 1'b0;
    chk("mid_busy0", busy, 0);
    chk("mid_valid0", valid, 0);
    chk("mid_ovf0", ovf, 0);
    step(1, 50);
    chk("mid_no_partial", valid, 0);
    step(1, 120); step(1, 90);
    chk("mid_valid", valid, 1);
    chk("mid_H", H, 120);
    chk("mid_T", T, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
